// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack sequencer: request opcodes and FSM states.
package stack_seq_pkg;

   typedef enum logic [1:0] {
      STK_PUSH = 2'b00,
      STK_POP  = 2'b01,
      STK_CALL = 2'b10,
      STK_RET  = 2'b11
   } stk_op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR_A = 3'd1,
      S_WR_B = 3'd2,
      S_RD_A = 3'd3,
      S_RD_B = 3'd4,
      S_RD_C = 3'd5,
      S_DONE = 3'd6
   } stk_state_e;

endpackage

// File: rtl/stack_addr_gen.sv
// Combinational stack address / SP arithmetic (modulo 2^DATA_W) with wrap flags.
module stack_addr_gen
   import stack_seq_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] wp,
   input  stk_state_e        state,
   input  stk_op_e           op,
   output logic [DATA_W-1:0] ram_addr,
   output logic [DATA_W-1:0] sp_new,
   output logic              stk_ovf,
   output logic              stk_udf
);

   logic [DATA_W:0]   wp_p1;
   logic [DATA_W:0]   wp_p2;
   logic [DATA_W-1:0] wp_m1;
   logic [DATA_W-1:0] wp_m2;

   // The extra MSB of the up-sums is the overflow carry.
   assign wp_p1 = {1'b0, wp} + (DATA_W+1)'(1);
   assign wp_p2 = {1'b0, wp} + (DATA_W+1)'(2);
   assign wp_m1 = wp - DATA_W'(1);
   assign wp_m2 = wp - DATA_W'(2);

   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      ram_addr = '0;
      sp_new   = '0;
      stk_ovf  = 1'b0;
      stk_udf  = 1'b0;
      case (state)
         S_WR_A: ram_addr = wp_p1[DATA_W-1:0];
         S_WR_B: ram_addr = wp_p2[DATA_W-1:0];
         S_RD_A: ram_addr = wp;
         S_RD_B: ram_addr = wp_m1;
         S_DONE: begin
            case (op)
               STK_PUSH: begin
                  sp_new  = wp_p1[DATA_W-1:0];
                  stk_ovf = wp_p1[DATA_W];
               end
               STK_CALL: begin
                  sp_new  = wp_p2[DATA_W-1:0];
                  stk_ovf = wp_p2[DATA_W];
               end
               STK_POP: begin
                  sp_new  = wp_m1;
                  stk_udf = (wp < DATA_W'(1));
               end
               default: begin
                  sp_new  = wp_m2;
                  stk_udf = (wp < DATA_W'(2));
               end
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/stack_seq.sv
// Multi-cycle stack sequencer: PUSH/POP/CALL/RET against internal RAM, returns updated SP.
module stack_seq
   import stack_seq_pkg::*;
#(
   parameter int PC_W   = 16,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              op_valid,
   input  logic [1:0]        op_code,
   output logic              op_ready,
   input  logic [DATA_W-1:0] push_data,
   input  logic [PC_W-1:0]   call_pc,
   input  logic [DATA_W-1:0] sp_in,
   output logic [DATA_W-1:0] sp_new,
   output logic              sp_load,
   output logic [DATA_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wr,
   output logic              ram_rd,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] pop_data,
   output logic [PC_W-1:0]   ret_pc,
   output logic              done,
   output logic              stk_ovf,
   output logic              stk_udf
);

   stk_state_e        state, state_nx;
   stk_op_e           op_r;
   logic [DATA_W-1:0] data_r;
   logic [PC_W-1:0]   pc_r;
   logic [DATA_W-1:0] wp;
   logic              accept;

   assign op_ready = (state == S_IDLE);
   assign accept   = op_valid && op_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         op_r     <= STK_PUSH;
         data_r   <= '0;
         pc_r     <= '0;
         wp       <= '0;
         pop_data <= '0;
         ret_pc   <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_r   <= stk_op_e'(op_code);
            data_r <= push_data;
            pc_r   <= call_pc;
            wp     <= sp_in;
         end
         // Read data lags ram_rd by one cycle: RD_B sees byte @wp, RD_C sees the last read.
         if (state == S_RD_B)
            ret_pc[PC_W-1:DATA_W] <= ram_rdata;
         if (state == S_RD_C) begin
            if (op_r == STK_POP)
               pop_data <= ram_rdata;
            else
               ret_pc[DATA_W-1:0] <= ram_rdata;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (op_valid) begin
               if (op_code == STK_PUSH || op_code == STK_CALL)
                  state_nx = S_WR_A;
               else
                  state_nx = S_RD_A;
            end
         end
         S_WR_A:  state_nx = (op_r == STK_CALL) ? S_WR_B : S_DONE;
         S_WR_B:  state_nx = S_DONE;
         S_RD_A:  state_nx = (op_r == STK_RET) ? S_RD_B : S_RD_C;
         S_RD_B:  state_nx = S_RD_C;
         S_RD_C:  state_nx = S_DONE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      ram_wdata = '0;
      if (state == S_WR_A)
         ram_wdata = (op_r == STK_CALL) ? pc_r[DATA_W-1:0] : data_r;
      else if (state == S_WR_B)
         ram_wdata = pc_r[PC_W-1:DATA_W];
   end

   assign ram_wr  = (state == S_WR_A) || (state == S_WR_B);
   assign ram_rd  = (state == S_RD_A) || (state == S_RD_B);
   assign done    = (state == S_DONE);
   assign sp_load = done;

   stack_addr_gen #(.DATA_W(DATA_W)) u_addr_gen (
      .wp       (wp),
      .state    (state),
      .op       (op_r),
      .ram_addr (ram_addr),
      .sp_new   (sp_new),
      .stk_ovf  (stk_ovf),
      .stk_udf  (stk_udf)
   );

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: directed cases plus randomized ops against a byte-array model.
module tb_stack_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [1:0]  op_code;
   logic        op_ready;
   logic [7:0]  push_data;
   logic [15:0] call_pc;
   logic [7:0]  sp_in;
   logic [7:0]  sp_new;
   logic        sp_load;
   logic [7:0]  ram_addr;
   logic [7:0]  ram_wdata;
   logic        ram_wr;
   logic        ram_rd;
   logic [7:0]  ram_rdata = 8'h00;
   logic [7:0]  pop_data;
   logic [15:0] ret_pc;
   logic        done;
   logic        stk_ovf;
   logic        stk_udf;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];
   bit         mem_init = 1'b0;

   always #5 clock = ~clock;

   stack_seq dut (
      .clock     (clock),
      .reset     (reset),
      .op_valid  (op_valid),
      .op_code   (op_code),
      .op_ready  (op_ready),
      .push_data (push_data),
      .call_pc   (call_pc),
      .sp_in     (sp_in),
      .sp_new    (sp_new),
      .sp_load   (sp_load),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_wr    (ram_wr),
      .ram_rd    (ram_rd),
      .ram_rdata (ram_rdata),
      .pop_data  (pop_data),
      .ret_pc    (ret_pc),
      .done      (done),
      .stk_ovf   (stk_ovf),
      .stk_udf   (stk_udf)
   );

   // RAM: synchronous write, read data one cycle after ram_rd.
   always @(posedge clock) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
         mem_init <= 1'b1;
      end else begin
         if (ram_wr) mem[ram_addr] <= ram_wdata;
         if (ram_rd) ram_rdata <= mem[ram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"}, op_ready, 1);
      check({tag, "_strobes"}, {ram_wr, ram_rd, done, sp_load, stk_ovf, stk_udf}, 0);
      check({tag, "_addr"}, {ram_addr, ram_wdata, sp_new}, 0);
   endtask

   // One transaction: expected RAM traffic and results come from the stack rules, not the RTL.
   task automatic do_op(input logic [1:0] op, input logic [7:0] data, input logic [15:0] pc,
                        input logic [7:0] sp, input bit hold);
      int         lat;
      int         sum;
      logic       e_wr [4];
      logic       e_rd [4];
      logic [7:0] e_ad [4];
      logic [7:0] e_wd [4];
      logic [7:0] e_sp;
      logic       e_ovf, e_udf;
      logic [7:0] e_pop;
      logic [15:0] e_ret;
      for (int c = 0; c < 4; c++) begin
         e_wr[c] = 0; e_rd[c] = 0; e_ad[c] = 0; e_wd[c] = 0;
      end
      e_ovf = 0; e_udf = 0; e_pop = 'x; e_ret = 'x;
      case (op)
         2'b00: begin
            lat = 2; sum = int'(sp) + 1;
            e_wr[1] = 1; e_ad[1] = 8'(sum); e_wd[1] = data;
            e_sp = 8'(sum); e_ovf = (sum > 255);
         end
         2'b10: begin
            lat = 3; sum = int'(sp) + 2;
            e_wr[1] = 1; e_ad[1] = 8'(sp + 8'd1); e_wd[1] = pc[7:0];
            e_wr[2] = 1; e_ad[2] = 8'(sum);       e_wd[2] = pc[15:8];
            e_sp = 8'(sum); e_ovf = (sum > 255);
         end
         2'b01: begin
            lat = 3;
            e_rd[1] = 1; e_ad[1] = sp;
            e_sp = sp - 8'd1; e_udf = (int'(sp) < 1);
            e_pop = ref_mem[sp];
         end
         default: begin
            lat = 4;
            e_rd[1] = 1; e_ad[1] = sp;
            e_rd[2] = 1; e_ad[2] = sp - 8'd1;
            e_sp = sp - 8'd2; e_udf = (int'(sp) < 2);
            e_ret = {ref_mem[sp], ref_mem[8'(sp - 8'd1)]};
         end
      endcase

      @(negedge clock);
      op_valid = 1; op_code = op; push_data = data; call_pc = pc; sp_in = sp;
      #1 check("accept_ready", op_ready, 1);
      @(posedge clock);
      #1;
      if (!hold) op_valid = 0;
      sp_in = 8'($urandom); push_data = 8'($urandom); call_pc = 16'($urandom);

      for (int c = 1; c < lat; c++) begin
         @(negedge clock);
         check("busy_ready", op_ready, 0);
         check("busy_done", {done, sp_load}, 0);
         check("ram_wr", ram_wr, e_wr[c]);
         check("ram_rd", ram_rd, e_rd[c]);
         check("ram_addr", ram_addr, e_ad[c]);
         check("ram_wdata", ram_wdata, e_wd[c]);
         if (e_wr[c]) ref_mem[e_ad[c]] = e_wd[c];
      end

      @(negedge clock);
      check("done", {done, sp_load}, 2'b11);
      check("done_strobes", {ram_wr, ram_rd}, 0);
      check("sp_new", sp_new, e_sp);
      check("stk_ovf", stk_ovf, e_ovf);
      check("stk_udf", stk_udf, e_udf);
      if (op == 2'b01) check("pop_data", pop_data, e_pop);
      if (op == 2'b11) check("ret_pc", ret_pc, e_ret);
   endtask

   initial begin
      logic [7:0] sp_pick;
      logic [7:0] wrap_sp [4];
      wrap_sp[0] = 8'h00; wrap_sp[1] = 8'h01; wrap_sp[2] = 8'hFE; wrap_sp[3] = 8'hFF;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);

      reset = 0; op_valid = 0; op_code = 0; push_data = 0; call_pc = 0; sp_in = 0;
      repeat (3) @(negedge clock);
      check_idle_outputs("reset");
      check("reset_data", {pop_data, ret_pc}, 0);
      reset = 1;

      // Directed cases from the stack rules.
      do_op(2'b00, 8'hA5, 16'h0000, 8'h07, 0);
      do_op(2'b10, 8'h00, 16'h1234, 8'h30, 0);
      do_op(2'b11, 8'h00, 16'h0000, 8'h32, 0);
      do_op(2'b10, 8'h00, 16'hBEEF, 8'hFF, 0);
      do_op(2'b01, 8'h00, 16'h0000, 8'h00, 0);
      do_op(2'b11, 8'h00, 16'h0000, 8'h01, 0);
      do_op(2'b00, 8'h3C, 16'h0000, 8'hFF, 0);

      // Busy: request held across a PUSH is ignored, then accepted once IDLE.
      do_op(2'b00, 8'h5A, 16'h0000, 8'h40, 1);
      do_op(2'b01, 8'h00, 16'h0000, 8'h41, 0);

      // Reset during CALL WR_B aborts: second byte never written.
      @(negedge clock);
      op_valid = 1; op_code = 2'b10; call_pc = 16'hCAFE; sp_in = 8'h60;
      @(posedge clock);
      #1 op_valid = 0;
      @(negedge clock);
      check("abort_wr_a", {ram_wr, ram_addr, ram_wdata}, {1'b1, 8'h61, 8'hFE});
      ref_mem[8'h61] = 8'hFE;
      @(negedge clock);
      check("abort_wr_b", {ram_wr, ram_addr}, {1'b1, 8'h62});
      reset = 0;
      #1 check_idle_outputs("abort");
      @(negedge clock);
      check("abort_hold", {done, sp_load, ram_wr}, 0);
      reset = 1;
      @(negedge clock);
      check_idle_outputs("post_abort");
      check("post_abort_data", {pop_data, ret_pc}, 0);
      do_op(2'b11, 8'h00, 16'h0000, 8'h62, 0);

      // Randomized ops, biased toward the wrap boundaries.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0) sp_pick = wrap_sp[$urandom_range(0, 3)];
         else sp_pick = 8'($urandom);
         do_op(2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom), sp_pick, 0);
      end

      @(negedge clock);
      check("final_ready", op_ready, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Multi-cycle sequencer that performs stack memory transactions (PUSH, POP, LCALL-style CALL, RET) on internal data RAM.
- Sits downstream of the SP register block: it consumes the current SP value, generates RAM addresses and data from it, and returns the updated SP with a load strobe.
- Sits between the decoder/control unit (requester) and the internal-RAM port. PC bytes for CALL/RET come from and go to the PC unit.

Parameters:
- PC_W, 16, program counter width; CALL/RET move exactly two bytes, so only 16 is supported.
- DATA_W, 8, RAM data and SP width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- op_valid  in  1  request strobe from control unit.
- op_code  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET.
- op_ready  out  1  high in IDLE; a request is accepted when op_valid & op_ready.
- push_data  in  8  byte to push; sampled at acceptance.
- call_pc  in  16  return address for CALL; sampled at acceptance.
- sp_in  in  8  current SP from SP block; sampled at acceptance.
- sp_new  out  8  updated SP value; valid when sp_load=1.
- sp_load  out  1  one-cycle strobe telling the SP block to load sp_new.
- ram_addr  out  8  internal RAM address.
- ram_wdata  out  8  RAM write data.
- ram_wr  out  1  RAM write strobe, one cycle per byte.
- ram_rd  out  1  RAM read strobe; read data returns exactly one cycle later.
- ram_rdata  in  8  RAM read data.
- pop_data  out  8  popped byte (POP); held until next acceptance.
- ret_pc  out  16  restored PC (RET); held until next acceptance.
- done  out  1  one-cycle completion pulse, coincident with sp_load.
- stk_ovf  out  1  one-cycle pulse at done if PUSH/CALL wrapped through 0xFF->0x00.
- stk_udf  out  1  one-cycle pulse at done if POP/RET wrapped through 0x00->0xFF.

Behaviour:
- Reset (reset=0, async): state=IDLE, op_ready=1. All other outputs 0, including pop_data, ret_pc, sp_new and ram_addr.
- Acceptance in IDLE latches op_code, push_data, call_pc, and sp_in into a working pointer wp. The state leaves IDLE on the next edge, and op_ready drops.
- op_valid while not IDLE is ignored; no queueing.
- States: IDLE, WR_A, WR_B, RD_A, RD_B, RD_C, DONE. Each state lasts one cycle.
- PUSH: IDLE -> WR_A (ram_wr=1, addr=wp+1, wdata=push_data) -> DONE (sp_new=wp+1).
  - Latency: done 2 cycles after acceptance.
- CALL: IDLE -> WR_A (addr=wp+1, wdata=call_pc[7:0]) -> WR_B (addr=wp+2, wdata=call_pc[15:8]) -> DONE (sp_new=wp+2).
  - Latency 3.
- POP: IDLE -> RD_A (ram_rd=1, addr=wp) -> RD_C (capture ram_rdata into pop_data) -> DONE (sp_new=wp-1).
  - Latency 3.
- RET: IDLE -> RD_A (ram_rd=1, addr=wp) -> RD_B (ram_rd=1, addr=wp-1, capture ret_pc[15:8]) -> RD_C (capture ret_pc[7:0]) -> DONE (sp_new=wp-2).
  - Latency 4.
- DONE: sp_load=1, done=1, flags valid. Next state is IDLE, so op_ready returns the cycle after done. Back-to-back issue is therefore one request per (latency+1) cycles.
- Arithmetic: all address and SP math is modulo 256; no saturation.
  - stk_ovf when the 9-bit sum wp+k exceeds 0xFF.
  - stk_udf when wp<k for POP (k=1) or RET (k=2).
- ram_wr and ram_rd are never high in the same cycle. Outside the listed states both are 0 and ram_addr/ram_wdata hold 0.
- Reset mid-operation aborts immediately: no further RAM strobes, no sp_load. RAM bytes already written stay written.
- sp_in changes after acceptance have no effect; only the latched wp is used.

Decomposition:
- Shared header define_opcodes.v gains:
  - STK_PUSH/STK_POP/STK_CALL/STK_RET op encodings.
  - Stack sequencer state encodings.
- One natural sub-module, stack_addr_gen: combinational; given wp, state and op, produces ram_addr, sp_new, stk_ovf and stk_udf.
- The FSM, capture registers and strobes remain in stack_seq.

Test Plan:
- Reset release, PUSH with sp_in=0x07, push_data=0xA5 -> WR_A cycle: ram_wr=1, addr=0x08, wdata=0xA5. Next cycle: done=1, sp_load=1, sp_new=0x08, stk_ovf=0.
- CALL with sp_in=0x30, call_pc=0x1234 -> write 0x34@0x31, then 0x12@0x32 on consecutive cycles; done with sp_new=0x32; total 3 cycles.
- RET with sp_in=0x32, RAM model holding 0x12@0x32 and 0x34@0x31 -> reads at 0x32 then 0x31; ret_pc=0x1234 and sp_new=0x30 at done; latency 4.
- Wrap cases:
  - CALL with sp_in=0xFF, call_pc=0xBEEF -> writes 0xEF@0x00, 0xBE@0x01; sp_new=0x01; stk_ovf=1.
  - POP with sp_in=0x00 -> read addr 0x00; sp_new=0xFF; stk_udf=1.
- Busy handling: a second op_valid during an active PUSH is ignored (no extra RAM strobe). The request held through the cycle after done is accepted.
- Reset asserted during CALL WR_B -> all strobes 0 immediately; no sp_load or done. After release, op_ready=1 and outputs are 0.
